// File: rtl/mem_bus_target_if.sv
// Memory-bus bundle between control (master) and the memory target (slave).
// Stats signals exist only when MEM_BUS_TARGET_STATS_EN is defined.
interface mem_bus_target_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 12
);
    logic [ADDR_W-1:0] bus_addr_data;
    logic              read_write;
    logic              write_commit;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] mem_result;
    logic              store_pending;
    logic              halted;
    logic              proto_err;
`ifdef MEM_BUS_TARGET_STATS_EN
    logic [15:0]       rd_count;
    logic [15:0]       st_count;
    logic [7:0]        err_count;
`endif

    modport master (
        output bus_addr_data, read_write, write_commit, load_en, load_addr, load_data,
`ifdef MEM_BUS_TARGET_STATS_EN
        input  rd_count, st_count, err_count,
`endif
        input  mem_result, store_pending, halted, proto_err
    );

    modport slave (
        input  bus_addr_data, read_write, write_commit, load_en, load_addr, load_data,
`ifdef MEM_BUS_TARGET_STATS_EN
        output rd_count, st_count, err_count,
`endif
        output mem_result, store_pending, halted, proto_err
    );
endinterface

// File: rtl/mem_bus_target.sv
// Memory-side bus endpoint: word store, registered 1-cycle reads, split half-word stores, sticky HALT.
// Define MEM_BUS_TARGET_STATS_EN to add saturating read/store/error counters.
module mem_bus_target #(
    parameter int              ADDR_W     = 10,
    parameter int              DATA_W     = 12,
    parameter logic [DATA_W-1:0] RESULT_RST = 'hF00
) (
    input  logic              clk,
    input  logic              rst,
    mem_bus_target_if.slave   bus_io
);
    localparam int HALF = DATA_W / 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR_PEND,
        ST_HALTED
    } state_t;

    // Bus cycle codes as {read_write, write_commit}
    localparam logic [1:0] CYC_STORE_ADDR = 2'b00;
    localparam logic [1:0] CYC_STORE_DATA = 2'b01;
    localparam logic [1:0] CYC_READ       = 2'b10;
    localparam logic [1:0] CYC_HALT       = 2'b11;

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic              proto_err_q, proto_err_d;
    logic [DATA_W-1:0] mem_result_q;

    logic              rd_fire, st_fire, err_fire, ld_fire;
    logic [1:0]        cyc;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign cyc = {bus_io.read_write, bus_io.write_commit};

    always_comb begin
        state_d     = state_q;
        pend_addr_d = pend_addr_q;
        rd_fire     = 1'b0;
        st_fire     = 1'b0;
        err_fire    = 1'b0;
        ld_fire     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                ld_fire = bus_io.load_en;
                unique case (cyc)
                    CYC_READ:       rd_fire = 1'b1;
                    CYC_STORE_ADDR: begin
                        pend_addr_d = bus_io.bus_addr_data;
                        state_d     = ST_ADDR_PEND;
                    end
                    CYC_STORE_DATA: err_fire = 1'b1;
                    CYC_HALT:       state_d  = ST_HALTED;
                    default:        ;
                endcase
            end
            ST_ADDR_PEND: begin
                unique case (cyc)
                    CYC_READ: begin
                        rd_fire  = 1'b1;
                        err_fire = 1'b1;
                        state_d  = ST_IDLE;
                    end
                    CYC_STORE_ADDR: pend_addr_d = bus_io.bus_addr_data;
                    CYC_STORE_DATA: begin
                        st_fire = 1'b1;
                        state_d = ST_IDLE;
                    end
                    CYC_HALT:       state_d = ST_HALTED;
                    default:        ;
                endcase
            end
            default: ;
        endcase
        proto_err_d = proto_err_q | err_fire;
    end

    // Store and preload are mutually exclusive by state; reset suppresses both.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = bus_io.load_addr;
        mem_wdata = bus_io.load_data;
        if (!rst && st_fire) begin
            mem_we    = 1'b1;
            mem_waddr = pend_addr_q;
            mem_wdata = mem_q[pend_addr_q];
            if (bus_io.bus_addr_data[HALF])
                mem_wdata[DATA_W-1:HALF] = bus_io.bus_addr_data[HALF-1:0];
            else
                mem_wdata[HALF-1:0] = bus_io.bus_addr_data[HALF-1:0];
        end else if (!rst && ld_fire) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem_q[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pend_addr_q  <= '0;
            proto_err_q  <= 1'b0;
            mem_result_q <= RESULT_RST;
        end else begin
            state_q     <= state_d;
            pend_addr_q <= pend_addr_d;
            proto_err_q <= proto_err_d;
            if (rd_fire)
                mem_result_q <= mem_q[bus_io.bus_addr_data];
        end
    end

    assign bus_io.mem_result    = mem_result_q;
    assign bus_io.store_pending = (state_q == ST_ADDR_PEND);
    assign bus_io.halted        = (state_q == ST_HALTED);
    assign bus_io.proto_err     = proto_err_q;

`ifdef MEM_BUS_TARGET_STATS_EN
    logic [15:0] rd_count_q, st_count_q;
    logic [7:0]  err_count_q;

    // Fire strobes are already silent in HALTED, which freezes the counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count_q  <= '0;
            st_count_q  <= '0;
            err_count_q <= '0;
        end else begin
            if (rd_fire && rd_count_q != '1)
                rd_count_q <= rd_count_q + 16'd1;
            if (st_fire && st_count_q != '1)
                st_count_q <= st_count_q + 16'd1;
            if (err_fire && err_count_q != '1)
                err_count_q <= err_count_q + 8'd1;
        end
    end

    assign bus_io.rd_count  = rd_count_q;
    assign bus_io.st_count  = st_count_q;
    assign bus_io.err_count = err_count_q;
`endif
endmodule
